// File: rtl/minmax_pkg.sv
// Shared types for the min/max selector family: frame FSM states and a strict compare-select helper.
// Used by min_frame_tracker and extreme_reg.
package minmax_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    // Strict compare: with greater=1 returns cand > cur, otherwise cand < cur; ties never win.
    function automatic logic sel_better(input logic [31:0] cand,
                                        input logic [31:0] cur,
                                        input logic        greater);
        return greater ? (cand > cur) : (cand < cur);
    endfunction

endpackage

// File: rtl/extreme_reg.sv
// Value/index register pair tracking a running extreme (min or max by GREATER) over a frame.
// Latency: updates on the cycle after load. Backpressure: none, the caller gates load.
module extreme_reg
    import minmax_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int IDXW    = 3,
    parameter bit GREATER = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             first,
    input  logic [WIDTH-1:0] data,
    input  logic [IDXW-1:0]  pos,
    output logic [WIDTH-1:0] val,
    output logic [IDXW-1:0]  idx
);

    logic [WIDTH-1:0] val_d, val_q;
    logic [IDXW-1:0]  idx_d, idx_q;

    // The first sample of a frame loads unconditionally; later ones only on a strict win.
    always_comb begin
        val_d = val_q;
        idx_d = idx_q;
        if (load && (first || sel_better(32'(data), 32'(val_q), GREATER))) begin
            val_d = data;
            idx_d = pos;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            idx_q <= '0;
        end else begin
            val_q <= val_d;
            idx_q <= idx_d;
        end
    end

    assign val = val_q;
    assign idx = idx_q;

endmodule

// File: rtl/min_frame_tracker.sv
// Frame minimum (and, with TRACK_MAX_EN, maximum) tracker with first-occurrence indices.
// Latency: result valid 1 cycle after the last sample. Backpressure: in_ready low while a result waits.
module min_frame_tracker
    import minmax_pkg::*;
#(
    parameter  int WIDTH     = 4,
    parameter  int FRAME_LEN = 8,
    localparam int IDXW      = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [IDXW-1:0]  out_index
`ifdef TRACK_MAX_EN
    ,
    output logic [WIDTH-1:0] out_max,
    output logic [IDXW-1:0]  out_max_index
`endif
);

    localparam logic [IDXW-1:0] LAST = IDXW'(FRAME_LEN - 1);

    state_e          state_d, state_q;
    logic [IDXW-1:0] count_d, count_q;
    logic            out_valid_d, out_valid_q;
    logic            in_hs;
    logic            out_hs;
    logic            first;

    assign in_ready = (state_q == ACCUM) && !clear;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign first    = (count_q == '0);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            state_d     = ACCUM;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_hs) begin
                        if (count_q == LAST) begin
                            state_d     = DONE;
                            count_d     = '0;
                            out_valid_d = 1'b1;
                        end else begin
                            count_d = count_q + IDXW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_hs) begin
                        state_d     = ACCUM;
                        out_valid_d = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    // Result registers are only loaded in ACCUM, so they hold naturally while DONE waits.
    extreme_reg #(.WIDTH(WIDTH), .IDXW(IDXW), .GREATER(1'b0)) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (in_hs),
        .first (first),
        .data  (in_data),
        .pos   (count_q),
        .val   (out_min),
        .idx   (out_index)
    );

`ifdef TRACK_MAX_EN
    extreme_reg #(.WIDTH(WIDTH), .IDXW(IDXW), .GREATER(1'b1)) u_max (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (in_hs),
        .first (first),
        .data  (in_data),
        .pos   (count_q),
        .val   (out_max),
        .idx   (out_max_index)
    );
`endif

endmodule
